// File: rtl/mgmt_rx_drain_sequencer_pkg.sv
// Shared definitions for the management RX FIFO drain engine: register map,
// drain/APB state encodings and a saturating counter helper.
package mgmt_rx_drain_sequencer_pkg;

    localparam logic [11:0] REG_RX_BUF = 12'h000;
    localparam logic [11:0] REG_RX_POP = 12'h0ff8;
    localparam logic [11:0] REG_RX_LEN = 12'h0ffc;

    typedef enum logic [2:0] {
        IDLE, RD_LEN, RD_DATA, EMIT, POP, SETTLE, ABORT
    } drain_state_t;

    typedef enum logic [1:0] {
        APB_IDLE, APB_SETUP, APB_ACCESS
    } apb_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hffff_ffff) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mgmt_rx_drain_sequencer_if.sv
// APB bus between the drain engine (requester) and the RX FIFO (completer).
// Handshake: a transfer is psel=1,penable=0 for one cycle, then psel=1,penable=1
// until pready=1; paddr/pwrite/pwdata hold for the whole transfer.
interface mgmt_rx_drain_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport requester (output psel, penable, pwrite, paddr, pwdata,
                       input  prdata, pready, pslverr);
    modport completer (input  psel, penable, pwrite, paddr, pwdata,
                       output prdata, pready, pslverr);
    modport master    (output psel, penable, pwrite, paddr, pwdata,
                       input  prdata, pready, pslverr);
    modport slave     (input  psel, penable, pwrite, paddr, pwdata,
                       output prdata, pready, pslverr);
endinterface

// File: rtl/mgmt_rx_drain_sequencer_apb_single_requester.sv
// Single-outstanding APB requester: start is sampled only when idle, so a caller
// may hold it high; done pulses in the cycle the completer raises pready.
module apb_single_requester
    import mgmt_rx_drain_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        write,
    input  logic [11:0] addr,
    input  logic [15:0] wdata,
    output logic        done,
    output logic [15:0] rdata,
    output logic        err,
    output logic        busy,
    output apb_state_t  state,
    mgmt_rx_drain_sequencer_if.requester apb
);
    apb_state_t state_q, state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            APB_IDLE:   if (start) state_d = APB_SETUP;
            APB_SETUP:  state_d = APB_ACCESS;
            APB_ACCESS: if (apb.pready) state_d = APB_IDLE;
            default:    state_d = APB_IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so psel drops right after
    // pready, guaranteeing at least one idle cycle before the next setup.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= APB_IDLE;
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            apb.pwrite  <= 1'b0;
            apb.paddr   <= '0;
            apb.pwdata  <= '0;
        end else begin
            state_q     <= state_d;
            apb.psel    <= (state_d != APB_IDLE);
            apb.penable <= (state_d == APB_ACCESS);
            if (state_q == APB_IDLE && start) begin
                apb.pwrite <= write;
                apb.paddr  <= addr;
                apb.pwdata <= write ? wdata : 16'h0;
            end
        end
    end

    assign done  = (state_q == APB_ACCESS) && apb.pready;
    assign rdata = apb.prdata;
    assign err   = done && apb.pslverr;
    assign busy  = (state_q != APB_IDLE);
    assign state = state_q;

endmodule

// File: rtl/mgmt_rx_drain_sequencer.sv
// Autonomous RX FIFO drain: reads a frame length, burst-reads its halfwords onto
// a 16-bit valid/ready stream (word held until out_ready), then pops the frame.
module mgmt_rx_drain_sequencer
    import mgmt_rx_drain_sequencer_pkg::*;
#(
    parameter int          MAX_FRAME_LEN   = 1536,
    parameter logic [11:0] REG_RX_POP_ADDR = REG_RX_POP,
    parameter logic [11:0] REG_RX_LEN_ADDR = REG_RX_LEN
) (
    input  logic         pclk,
    input  logic         preset_n,
    mgmt_rx_drain_sequencer_if.requester apb,
    input  logic         rx_frame_ready,
    input  logic         eth_link_up,
    input  logic         enable,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [15:0]  out_data,
    output logic         out_bytes,
    output logic         out_start,
    output logic         out_last,
    output logic         out_abort,
    output logic [31:0]  frames_forwarded,
    output logic [31:0]  frames_dropped,
    output logic         busy,
    output drain_state_t dbg_state,
    output apb_state_t   dbg_apb_state
);
    localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME_LEN);

    drain_state_t state_q, state_d;
    logic [10:0]  remaining_q;
    logic [11:0]  addr_q;
    logic [15:0]  hold_q;
    logic         first_q, fwd_ok_q, link_abort_q, drop_done_q;

    logic         xfer_start, xfer_write, xfer_done, xfer_err, xfer_busy;
    logic [11:0]  xfer_addr;
    logic [15:0]  xfer_rdata;
    logic         start_frame, ld_len, ld_data, step, go_abort, abort_link;
    logic         inc_drop, inc_fwd;

    wire [10:0] len_rx    = xfer_rdata[10:0];
    wire        len_bad   = (len_rx == 11'd0) || (len_rx > MAX_LEN);
    wire        word_last = (remaining_q <= 11'd2);
    // Link loss is acted on only once no APB transfer is left in flight.
    wire        link_lost = !eth_link_up && (xfer_done || !xfer_busy);

    apb_single_requester u_apb (
        .clk   (pclk),
        .rst_n (preset_n),
        .start (xfer_start),
        .write (xfer_write),
        .addr  (xfer_addr),
        .wdata (16'h0),
        .done  (xfer_done),
        .rdata (xfer_rdata),
        .err   (xfer_err),
        .busy  (xfer_busy),
        .state (dbg_apb_state),
        .apb   (apb)
    );

    always_comb begin
        state_d     = state_q;
        xfer_start  = 1'b0;
        xfer_write  = 1'b0;
        xfer_addr   = addr_q;
        start_frame = 1'b0;
        ld_len      = 1'b0;
        ld_data     = 1'b0;
        step        = 1'b0;
        go_abort    = 1'b0;
        abort_link  = 1'b0;
        inc_drop    = 1'b0;
        inc_fwd     = 1'b0;
        case (state_q)
            IDLE: if (enable && eth_link_up && rx_frame_ready) begin
                start_frame = 1'b1;
                state_d     = RD_LEN;
            end
            RD_LEN: begin
                xfer_start = eth_link_up;
                xfer_addr  = REG_RX_LEN_ADDR;
                if (xfer_done && eth_link_up) begin
                    if (xfer_err || len_bad) begin
                        inc_drop = 1'b1;
                        state_d  = POP;
                    end else begin
                        ld_len  = 1'b1;
                        state_d = RD_DATA;
                    end
                end else if (link_lost) begin
                    inc_drop = 1'b1;
                    state_d  = IDLE;
                end
            end
            RD_DATA: begin
                xfer_start = eth_link_up;
                if (xfer_done && eth_link_up) begin
                    if (xfer_err) begin
                        inc_drop = 1'b1;
                        go_abort = 1'b1;
                        state_d  = ABORT;
                    end else begin
                        ld_data = 1'b1;
                        state_d = EMIT;
                    end
                end else if (link_lost) begin
                    inc_drop = 1'b1;
                    if (!first_q) begin
                        go_abort   = 1'b1;
                        abort_link = 1'b1;
                        state_d    = ABORT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            EMIT: if (out_ready) begin
                step = 1'b1;
                if (!eth_link_up) begin
                    inc_drop = 1'b1;
                    if (word_last) begin
                        state_d = IDLE;
                    end else begin
                        go_abort   = 1'b1;
                        abort_link = 1'b1;
                        state_d    = ABORT;
                    end
                end else begin
                    state_d = word_last ? POP : RD_DATA;
                end
            end
            ABORT: if (out_ready) begin
                if (link_abort_q || !eth_link_up) begin
                    inc_drop = 1'b1;
                    state_d  = IDLE;
                end else begin
                    state_d = POP;
                end
            end
            POP: begin
                xfer_start = eth_link_up;
                xfer_write = 1'b1;
                xfer_addr  = REG_RX_POP_ADDR;
                if (xfer_done && eth_link_up) begin
                    inc_fwd = fwd_ok_q;
                    state_d = SETTLE;
                end else if (link_lost) begin
                    inc_drop = 1'b1;
                    state_d  = IDLE;
                end
            end
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // drop_done_q keeps a frame from being counted twice when link loss follows an error.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q          <= IDLE;
            remaining_q      <= '0;
            addr_q           <= '0;
            hold_q           <= '0;
            first_q          <= 1'b0;
            fwd_ok_q         <= 1'b0;
            link_abort_q     <= 1'b0;
            drop_done_q      <= 1'b0;
            frames_forwarded <= '0;
            frames_dropped   <= '0;
        end else begin
            state_q <= state_d;
            if (start_frame) begin
                drop_done_q <= 1'b0;
                fwd_ok_q    <= 1'b0;
            end
            if (ld_len) begin
                remaining_q <= len_rx;
                addr_q      <= '0;
                first_q     <= 1'b1;
            end
            if (ld_data)
                hold_q <= (remaining_q == 11'd1) ? {xfer_rdata[15:8], 8'h00} : xfer_rdata;
            if (step) begin
                remaining_q <= remaining_q - (word_last ? remaining_q : 11'd2);
                addr_q      <= addr_q + 12'd2;
                first_q     <= 1'b0;
                if (word_last) fwd_ok_q <= 1'b1;
            end
            if (go_abort) link_abort_q <= abort_link;
            if (inc_drop && !drop_done_q) begin
                frames_dropped <= sat_inc(frames_dropped);
                drop_done_q    <= 1'b1;
            end
            if (inc_fwd) frames_forwarded <= sat_inc(frames_forwarded);
        end
    end

    assign out_valid = (state_q == EMIT) || (state_q == ABORT);
    assign out_data  = (state_q == EMIT) ? hold_q : 16'h0;
    assign out_bytes = (state_q == EMIT) && (remaining_q == 11'd1);
    assign out_start = out_valid && first_q;
    assign out_last  = (state_q == ABORT) || ((state_q == EMIT) && word_last);
    assign out_abort = (state_q == ABORT);
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mgmt_rx_drain_sequencer.sv
// Directed bench for the RX drain sequencer: APB completer model with a frame
// queue, stream scoreboard and APB transaction scoreboard.
module tb_mgmt_rx_drain_sequencer;
    import mgmt_rx_drain_sequencer_pkg::*;

    logic         pclk = 1'b0;
    logic         preset_n = 1'b0;
    logic         rx_frame_ready = 1'b0;
    logic         eth_link_up = 1'b1;
    logic         enable = 1'b1;
    logic         out_valid, out_ready, out_bytes, out_start, out_last, out_abort, busy;
    logic [15:0]  out_data;
    logic [31:0]  frames_forwarded, frames_dropped;
    drain_state_t dbg_state;
    apb_state_t   dbg_apb_state;

    mgmt_rx_drain_sequencer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(12)) apb ();

    mgmt_rx_drain_sequencer dut (
        .pclk             (pclk),
        .preset_n         (preset_n),
        .apb              (apb),
        .rx_frame_ready   (rx_frame_ready),
        .eth_link_up      (eth_link_up),
        .enable           (enable),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_bytes        (out_bytes),
        .out_start        (out_start),
        .out_last         (out_last),
        .out_abort        (out_abort),
        .frames_forwarded (frames_forwarded),
        .frames_dropped   (frames_dropped),
        .busy             (busy),
        .dbg_state        (dbg_state),
        .dbg_apb_state    (dbg_apb_state)
    );

    // clock / reset
    always #5 pclk = ~pclk;

    int          errors = 0;
    int          checks = 0;
    logic [19:0] exp_q[$];      // {abort, last, start, bytes, data}
    logic [12:0] exp_apb_q[$];  // {pwrite, paddr}
    int          len_q[$];
    logic [7:0]  base_q[$];
    int          ws = 1;
    int          pop_cd = 0;
    bit          err_len_arm = 1'b0;
    bit          link_drop_arm = 1'b0;
    bit          ready_toggle = 1'b0;
    int          exp_fwd = 0;
    int          exp_drop = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // APB completer model: ws wait states, optional pslverr on the length read,
    // FIFO header advancing two cycles after a pop completes.
    initial begin
        int          wcnt;
        int          dummy;
        logic [12:0] setup_txn;
        logic [7:0]  b;
        logic [7:0]  b1;
        wcnt = 0;
        setup_txn = '0;
        apb.prdata = '0;
        apb.pready = 1'b0;
        apb.pslverr = 1'b0;
        forever begin
            @(posedge pclk);
            #1;
            apb.pready = 1'b0;
            apb.pslverr = 1'b0;
            apb.prdata = '0;
            if (pop_cd > 0) begin
                pop_cd--;
                if (pop_cd == 0) begin
                    if (len_q.size() > 0) begin
                        dummy = len_q.pop_front();
                        b = base_q.pop_front();
                    end
                    rx_frame_ready = (len_q.size() > 0);
                end
            end
            if (apb.psel && !apb.penable) begin
                setup_txn = {apb.pwrite, apb.paddr};
                wcnt = 0;
            end else if (apb.psel && apb.penable) begin
                if (link_drop_arm && !apb.pwrite && apb.paddr == 12'h006) begin
                    link_drop_arm = 1'b0;
                    eth_link_up = 1'b0;
                    len_q.delete();
                    base_q.delete();
                    rx_frame_ready = 1'b0;
                end
                if (wcnt >= ws) begin
                    apb.pready = 1'b1;
                    check("apb_addr_stable", 32'({apb.pwrite, apb.paddr}), 32'(setup_txn));
                    if (exp_apb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL apb_unexpected: got %h expected none", {apb.pwrite, apb.paddr});
                    end else begin
                        check("apb_txn", 32'({apb.pwrite, apb.paddr}), 32'(exp_apb_q.pop_front()));
                    end
                    if (apb.pwrite) begin
                        check("apb_pwdata", 32'(apb.pwdata), 32'h0);
                        if (apb.paddr == REG_RX_POP) pop_cd = 2;
                    end else if (apb.paddr == REG_RX_LEN) begin
                        apb.prdata = (len_q.size() > 0) ? 16'(len_q[0]) : 16'h0;
                        if (err_len_arm) begin
                            apb.pslverr = 1'b1;
                            err_len_arm = 1'b0;
                        end
                    end else if (base_q.size() > 0) begin
                        b  = base_q[0] + apb.paddr[7:0];
                        b1 = b + 8'd1;
                        apb.prdata = {b, b1};
                    end
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // consumer: ready always high or toggling every cycle
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge pclk);
            #1;
            out_ready = ready_toggle ? ~out_ready : 1'b1;
        end
    end

    // stream monitor / scoreboard
    initial begin
        logic [19:0] cur;
        logic [19:0] prev;
        bit          stalled;
        stalled = 1'b0;
        prev = '0;
        forever begin
            @(negedge pclk);
            cur = {out_abort, out_last, out_start, out_bytes, out_data};
            if (preset_n && out_valid) begin
                if (stalled) check("stall_stable", 32'(cur), 32'(prev));
                if (out_ready) begin
                    stalled = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL stream_unexpected: got %h expected none", cur);
                    end else begin
                        check("stream_word", 32'(cur), 32'(exp_q.pop_front()));
                    end
                end else begin
                    stalled = 1'b1;
                    prev = cur;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    // driver tasks
    task automatic push_frame(input int len, input logic [7:0] base);
        int         rem;
        logic [7:0] b0;
        logic [7:0] b1;
        exp_apb_q.push_back({1'b0, REG_RX_LEN});
        if (len >= 1 && len <= 1536) begin
            for (int i = 0; i < len; i += 2) begin
                rem = len - i;
                b0 = base + 8'(i);
                b1 = (rem == 1) ? 8'h00 : b0 + 8'd1;
                exp_apb_q.push_back({1'b0, 12'(i)});
                exp_q.push_back({1'b0, rem <= 2, i == 0, rem == 1, b0, b1});
            end
            exp_fwd++;
        end else begin
            exp_drop++;
        end
        exp_apb_q.push_back({1'b1, REG_RX_POP});
        len_q.push_back(len);
        base_q.push_back(base);
        rx_frame_ready = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(dbg_state == IDLE && exp_q.size() == 0 && exp_apb_q.size() == 0 &&
                 len_q.size() == 0 && pop_cd == 0) && n < 3000) begin
            @(posedge pclk);
            #1;
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL %s_timeout: got %0d cycles expected under 3000", name, n);
        end
        repeat (3) @(posedge pclk);
        #1;
    endtask

    task automatic check_counters(input string name);
        check({name, "_fwd"}, frames_forwarded, 32'(exp_fwd));
        check({name, "_drop"}, frames_dropped, 32'(exp_drop));
        check({name, "_state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    initial begin
        int n;
        repeat (3) @(posedge pclk);
        #1;
        check("rst_psel", 32'({apb.psel, apb.penable, apb.pwrite}), 32'h0);
        check("rst_paddr", 32'({apb.paddr, apb.pwdata}), 32'h0);
        check("rst_out", 32'({out_valid, out_start, out_last, out_abort, out_bytes, out_data}), 32'h0);
        check("rst_fwd", frames_forwarded, 32'h0);
        check("rst_drop", frames_dropped, 32'h0);
        check("rst_busy", 32'({busy, dbg_state}), 32'h0);
        preset_n = 1'b1;
        repeat (2) @(posedge pclk);
        #1;

        // len 6, bytes 01..06
        push_frame(6, 8'h01);
        wait_idle("len6");
        check_counters("len6");

        // len 5 with enable dropped mid-frame, then len 1 held off until re-enabled
        push_frame(5, 8'h01);
        n = 0;
        while (dbg_state == IDLE && n < 100) begin
            @(posedge pclk);
            #1;
            n++;
        end
        check("len5_started", 32'(n < 100), 32'h1);
        enable = 1'b0;
        wait_idle("len5");
        check_counters("len5");
        push_frame(1, 8'h0a);
        repeat (20) @(posedge pclk);
        #1;
        check("enable_hold_apb", 32'(exp_apb_q.size()), 32'd3);
        check("enable_hold_state", 32'(dbg_state), 32'(IDLE));
        enable = 1'b1;
        wait_idle("len1");
        check_counters("len1");

        // len 0 and len 1600 back to back: both popped, nothing forwarded
        push_frame(0, 8'h00);
        push_frame(1600, 8'h00);
        wait_idle("bad_len");
        check_counters("bad_len");

        // len 64 with out_ready toggling
        ready_toggle = 1'b1;
        push_frame(64, 8'h20);
        wait_idle("stall");
        check_counters("stall");
        ready_toggle = 1'b0;

        // link drop during the fourth data read of a len 100 frame
        exp_apb_q.push_back({1'b0, REG_RX_LEN});
        for (int i = 0; i < 4; i++) exp_apb_q.push_back({1'b0, 12'(2 * i)});
        exp_q.push_back({4'b0010, 16'h4041});
        exp_q.push_back({4'b0000, 16'h4243});
        exp_q.push_back({4'b0000, 16'h4445});
        exp_q.push_back({4'b1100, 16'h0000});
        exp_drop++;
        len_q.push_back(100);
        base_q.push_back(8'h40);
        link_drop_arm = 1'b1;
        rx_frame_ready = 1'b1;
        wait_idle("link_drop");
        check("link_drop_link", 32'(eth_link_up), 32'h0);
        check_counters("link_drop");
        eth_link_up = 1'b1;

        // 3 wait states, pslverr on the length read, then a good frame back to back
        ws = 3;
        err_len_arm = 1'b1;
        exp_apb_q.push_back({1'b0, REG_RX_LEN});
        exp_apb_q.push_back({1'b1, REG_RX_POP});
        exp_drop++;
        len_q.push_back(4);
        base_q.push_back(8'h60);
        push_frame(4, 8'h70);
        wait_idle("slverr");
        check_counters("slverr");
        check("final_psel", 32'({apb.psel, busy}), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        checks++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
